// File: rtl/znc_flag_cond.sv
// ZNC flag register, branch-condition evaluator and LIFO flag stack.
// Latency: flags, verdict and stack state update one clk after the triggering edge.
// Backpressure: none; requests are always accepted, and stack overflow/underflow sets a sticky error.
module znc_flag_cond #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] regA,
  input  logic [WIDTH-1:0] regB,
  input  logic [WIDTH-1:0] newRegA,
  input  logic             flag_we,
  input  logic             cond_req,
  input  logic [2:0]       cond_code,
  input  logic             push,
  input  logic             pop,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             cond_valid,
  output logic             cond_true,
  output logic [PTR_W:0]   stack_count,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

  // Stack entries are {z, n, c}.
  logic [2:0]       stackMem [DEPTH];
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   countDec;
  logic [PTR_W-1:0] wrIdx;
  logic [PTR_W-1:0] rdIdx;

  logic zReg, nReg, cReg;
  logic validReg, trueReg, errReg;
  logic isFull, isEmpty;
  logic pushOk, popOk, pushBad, popBad;
  logic signA, signB, signR;
  logic capZ, capN, capC;
  logic verdict;

  assign isFull  = (count == FULL_CNT);
  assign isEmpty = (count == '0);

  // A push and a pop in the same cycle cancel each other; neither touches the stack.
  assign pushOk  = push & ~pop & ~isFull;
  assign popOk   = pop & ~push & ~isEmpty;
  assign pushBad = push & ~pop & isFull;
  assign popBad  = pop & ~push & isEmpty;

  assign countDec = count - ONE_CNT;
  assign wrIdx    = count[PTR_W-1:0];
  assign rdIdx    = countDec[PTR_W-1:0];

  assign signA = regA[WIDTH-1];
  assign signB = regB[WIDTH-1];
  assign signR = newRegA[WIDTH-1];

  // Carry is the majority of the three sign bits.
  assign capZ = (newRegA == '0);
  assign capN = signR;
  assign capC = (signA & signB) | (signA & signR) | (signB & signR);

  // Decode the branch condition against the currently stored flags (no bypass of capture).
  always_comb begin
    verdict = 1'b0;
    case (cond_code)
      3'd0:    verdict = 1'b1;
      3'd1:    verdict = zReg;
      3'd2:    verdict = ~zReg;
      3'd3:    verdict = nReg;
      3'd4:    verdict = ~nReg;
      3'd5:    verdict = cReg;
      3'd6:    verdict = ~cReg;
      default: verdict = 1'b0;
    endcase
  end

  // Flag register: a successful pop restores saved flags and overrides a capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zReg <= 1'b0;
      nReg <= 1'b0;
      cReg <= 1'b0;
    end else if (popOk) begin
      {zReg, nReg, cReg} <= stackMem[rdIdx];
    end else if (flag_we) begin
      zReg <= capZ;
      nReg <= capN;
      cReg <= capC;
    end
  end

  // Stack storage holds pre-edge flags; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (pushOk) begin
      stackMem[wrIdx] <= {zReg, nReg, cReg};
    end
  end

  // Stack occupancy and sticky overflow/underflow error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      errReg <= 1'b0;
    end else begin
      if (pushOk) begin
        count <= count + ONE_CNT;
      end else if (popOk) begin
        count <= countDec;
      end
      if (pushBad || popBad) begin
        errReg <= 1'b1;
      end
    end
  end

  // Verdict pipeline: valid pulses once per request, verdict holds between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validReg <= 1'b0;
      trueReg  <= 1'b0;
    end else begin
      validReg <= cond_req;
      if (cond_req) begin
        trueReg <= verdict;
      end
    end
  end

  assign z           = zReg;
  assign n           = nReg;
  assign c           = cReg;
  assign cond_valid  = validReg;
  assign cond_true   = trueReg;
  assign stack_count = count;
  assign stack_full  = isFull;
  assign stack_empty = isEmpty;
  assign stack_err   = errReg;

endmodule

// File: tb/tb_znc_flag_cond.sv
// Directed bench for znc_flag_cond.
// Drives inputs between edges and samples 1 time unit after each rising edge.
// Expected values are hand-derived from the flag, condition and stack rules.
module tb_znc_flag_cond;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regB;
  logic [WIDTH-1:0] newRegA;
  logic             flag_we;
  logic             cond_req;
  logic [2:0]       cond_code;
  logic             push;
  logic             pop;
  logic             z;
  logic             n;
  logic             c;
  logic             cond_valid;
  logic             cond_true;
  logic [PTR_W:0]   stack_count;
  logic             stack_full;
  logic             stack_empty;
  logic             stack_err;

  int testsRun;
  int testsFailed;

  znc_flag_cond #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .regA       (regA),
    .regB       (regB),
    .newRegA    (newRegA),
    .flag_we    (flag_we),
    .cond_req   (cond_req),
    .cond_code  (cond_code),
    .push       (push),
    .pop        (pop),
    .z          (z),
    .n          (n),
    .c          (c),
    .cond_valid (cond_valid),
    .cond_true  (cond_true),
    .stack_count(stack_count),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .stack_err  (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    regA      = '0;
    regB      = '0;
    newRegA   = '0;
    flag_we   = 1'b0;
    cond_req  = 1'b0;
    cond_code = 3'd0;
    push      = 1'b0;
    pop       = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    testsRun++;
    if ({z, n, c, cond_valid, cond_true, stack_count, stack_full, stack_empty, stack_err} !== {5'b0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
      testsFailed++;
      $display("FAIL reset_state: got znc=%b%b%b v=%b t=%b cnt=%0d full=%b empty=%b err=%b, want all 0 with empty=1",
               z, n, c, cond_valid, cond_true, stack_count, stack_full, stack_empty, stack_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_flag_capture();
    regA = 16'h7FFF; regB = 16'h0001; newRegA = 16'h8000; flag_we = 1'b1;
    tick();
    idle_inputs();
    testsRun++;
    if ({z, n, c} !== 3'b010) begin
      testsFailed++;
      $display("FAIL capture_neg: znc got %b%b%b want 010", z, n, c);
    end
    // Sign bits 1,0,0: majority is 0, so no carry.
    regA = 16'hFFFF; regB = 16'h0001; newRegA = 16'h0000; flag_we = 1'b1;
    tick();
    idle_inputs();
    testsRun++;
    if ({z, n, c} !== 3'b100) begin
      testsFailed++;
      $display("FAIL capture_zero: znc got %b%b%b want 100", z, n, c);
    end
    // Sign bits 1,1,0: carry set, result zero.
    regA = 16'h8000; regB = 16'h8000; newRegA = 16'h0000; flag_we = 1'b1;
    tick();
    idle_inputs();
    testsRun++;
    if ({z, n, c} !== 3'b101) begin
      testsFailed++;
      $display("FAIL capture_carry: znc got %b%b%b want 101", z, n, c);
    end
  endtask

  task automatic test_cond_sweep();
    logic [7:0] expTrue;
    // Flags z=1 n=0 c=1; bit i is the expected verdict for code i.
    expTrue = 8'b0011_0011;
    for (int i = 0; i < 8; i++) begin
      cond_req  = 1'b1;
      cond_code = 3'(i);
      tick();
      testsRun++;
      if (cond_valid !== 1'b1 || cond_true !== expTrue[i]) begin
        testsFailed++;
        $display("FAIL cond_code_%0d: valid=%b true=%b want valid=1 true=%b", i, cond_valid, cond_true, expTrue[i]);
      end
    end
    idle_inputs();
    tick();
    testsRun++;
    if (cond_valid !== 1'b0 || cond_true !== 1'b0) begin
      testsFailed++;
      $display("FAIL cond_hold: valid=%b true=%b want valid=0 true=0", cond_valid, cond_true);
    end
  endtask

  task automatic test_no_bypass();
    newRegA = 16'h0001; flag_we = 1'b1;
    tick();
    idle_inputs();
    newRegA = 16'h0000; flag_we = 1'b1; cond_req = 1'b1; cond_code = 3'd1;
    tick();
    testsRun++;
    if (cond_valid !== 1'b1 || cond_true !== 1'b0 || z !== 1'b1) begin
      testsFailed++;
      $display("FAIL no_bypass: valid=%b true=%b z=%b want valid=1 true=0 z=1", cond_valid, cond_true, z);
    end
    flag_we = 1'b0;
    tick();
    idle_inputs();
    testsRun++;
    if (cond_valid !== 1'b1 || cond_true !== 1'b1) begin
      testsFailed++;
      $display("FAIL eq_after_capture: valid=%b true=%b want valid=1 true=1", cond_valid, cond_true);
    end
  endtask

  task automatic test_push_pop();
    regA = 16'h8000; regB = 16'h8000; newRegA = 16'h0000; flag_we = 1'b1;
    tick();
    idle_inputs();
    push = 1'b1;
    tick();
    idle_inputs();
    testsRun++;
    if (stack_count !== 3'd1 || {z, n, c} !== 3'b101) begin
      testsFailed++;
      $display("FAIL push_one: cnt=%0d znc=%b%b%b want cnt=1 znc=101", stack_count, z, n, c);
    end
    regA = 16'h8000; regB = 16'h8000; newRegA = 16'h8000; flag_we = 1'b1;
    tick();
    idle_inputs();
    testsRun++;
    if ({z, n, c} !== 3'b011) begin
      testsFailed++;
      $display("FAIL overwrite: znc got %b%b%b want 011", z, n, c);
    end
    pop = 1'b1;
    tick();
    idle_inputs();
    testsRun++;
    if ({z, n, c} !== 3'b101 || stack_count !== 3'd0 || stack_err !== 1'b0 || stack_empty !== 1'b1) begin
      testsFailed++;
      $display("FAIL pop_restore: znc=%b%b%b cnt=%0d err=%b empty=%b want 101 cnt=0 err=0 empty=1",
               z, n, c, stack_count, stack_err, stack_empty);
    end
  endtask

  task automatic test_push_pop_same();
    // Push saves 101 while the capture loads 010.
    push = 1'b1; newRegA = 16'h8000; flag_we = 1'b1;
    tick();
    idle_inputs();
    // Simultaneous push/pop: stack frozen, capture loads 001.
    push = 1'b1; pop = 1'b1; regA = 16'h8000; regB = 16'h8000; newRegA = 16'h0001; flag_we = 1'b1;
    tick();
    idle_inputs();
    testsRun++;
    if (stack_count !== 3'd1 || {z, n, c} !== 3'b001 || stack_err !== 1'b0) begin
      testsFailed++;
      $display("FAIL push_pop_same: cnt=%0d znc=%b%b%b err=%b want cnt=1 znc=001 err=0", stack_count, z, n, c, stack_err);
    end
    // Successful pop beats a simultaneous capture.
    pop = 1'b1; newRegA = 16'h8000; flag_we = 1'b1;
    tick();
    idle_inputs();
    testsRun++;
    if (stack_count !== 3'd0 || {z, n, c} !== 3'b101) begin
      testsFailed++;
      $display("FAIL pop_beats_capture: cnt=%0d znc=%b%b%b want cnt=0 znc=101", stack_count, z, n, c);
    end
  endtask

  task automatic test_overflow_underflow();
    logic [47:0] vecs [5];
    logic [2:0]  expFlags [5];
    vecs[0] = {16'h0000, 16'h0000, 16'h0000}; expFlags[0] = 3'b100;
    vecs[1] = {16'h0000, 16'h0000, 16'h8000}; expFlags[1] = 3'b010;
    vecs[2] = {16'h8000, 16'h8000, 16'h0001}; expFlags[2] = 3'b001;
    vecs[3] = {16'h8000, 16'h8000, 16'h0000}; expFlags[3] = 3'b101;
    vecs[4] = {16'h8000, 16'h8000, 16'h8000}; expFlags[4] = 3'b011;
    {regA, regB, newRegA} = vecs[0]; flag_we = 1'b1;
    tick();
    idle_inputs();
    for (int i = 1; i < 5; i++) begin
      {regA, regB, newRegA} = vecs[i]; flag_we = 1'b1; push = 1'b1;
      tick();
      idle_inputs();
      testsRun++;
      if ({z, n, c} !== expFlags[i] || stack_count !== 3'(i) || stack_full !== (i == 4) || stack_err !== 1'b0) begin
        testsFailed++;
        $display("FAIL push_%0d: znc=%b%b%b cnt=%0d full=%b err=%b want znc=%b cnt=%0d full=%b err=0",
                 i, z, n, c, stack_count, stack_full, stack_err, expFlags[i], i, (i == 4));
      end
    end
    push = 1'b1;
    tick();
    idle_inputs();
    testsRun++;
    if (stack_count !== 3'd4 || stack_full !== 1'b1 || stack_err !== 1'b1 || {z, n, c} !== 3'b011) begin
      testsFailed++;
      $display("FAIL overflow: cnt=%0d full=%b err=%b znc=%b%b%b want cnt=4 full=1 err=1 znc=011",
               stack_count, stack_full, stack_err, z, n, c);
    end
    for (int i = 0; i < 4; i++) begin
      pop = 1'b1;
      tick();
      idle_inputs();
      testsRun++;
      if ({z, n, c} !== expFlags[3-i] || stack_count !== 3'(3-i) || stack_empty !== (i == 3)) begin
        testsFailed++;
        $display("FAIL pop_%0d: znc=%b%b%b cnt=%0d empty=%b want znc=%b cnt=%0d empty=%b",
                 i, z, n, c, stack_count, stack_empty, expFlags[3-i], 3 - i, (i == 3));
      end
    end
    pop = 1'b1;
    tick();
    idle_inputs();
    testsRun++;
    if ({z, n, c} !== 3'b100 || stack_count !== 3'd0 || stack_empty !== 1'b1 || stack_err !== 1'b1) begin
      testsFailed++;
      $display("FAIL underflow: znc=%b%b%b cnt=%0d empty=%b err=%b want znc=100 cnt=0 empty=1 err=1",
               z, n, c, stack_count, stack_empty, stack_err);
    end
  endtask

  task automatic test_async_reset();
    regA = 16'hFFFF; regB = 16'hFFFF; newRegA = 16'hFFFF; flag_we = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      push = 1'b1;
      tick();
      idle_inputs();
    end
    cond_req = 1'b1; cond_code = 3'd0;
    tick();
    idle_inputs();
    testsRun++;
    if (cond_valid !== 1'b1 || cond_true !== 1'b1 || stack_count !== 3'd3 || {z, n, c} !== 3'b011) begin
      testsFailed++;
      $display("FAIL pre_reset: valid=%b true=%b cnt=%0d znc=%b%b%b want valid=1 true=1 cnt=3 znc=011",
               cond_valid, cond_true, stack_count, z, n, c);
    end
    #1;
    rst_n = 1'b0;
    #1;
    testsRun++;
    if ({z, n, c, cond_valid, cond_true, stack_count, stack_full, stack_empty, stack_err} !== {5'b0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
      testsFailed++;
      $display("FAIL async_reset: znc=%b%b%b v=%b t=%b cnt=%0d full=%b empty=%b err=%b want all 0 with empty=1",
               z, n, c, cond_valid, cond_true, stack_count, stack_full, stack_empty, stack_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    testsRun++;
    if (cond_valid !== 1'b0 || stack_count !== 3'd0 || stack_err !== 1'b0) begin
      testsFailed++;
      $display("FAIL post_reset: valid=%b cnt=%0d err=%b want 0 0 0", cond_valid, stack_count, stack_err);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    test_reset();
    test_flag_capture();
    test_cond_sweep();
    test_no_bypass();
    test_push_pop();
    test_push_pop_same();
    test_overflow_underflow();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
